// File: rtl/midterm_128bit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : midterm_128bit
// Description : Registered ALU with an arithmetic and a logic mode.
//               Produces a WIDTH-bit result plus carry, zero, overflow and
//               sign flags, with one cycle of latency.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module midterm_128bit #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       opsel,
    input  logic             mode,
    output logic [WIDTH-1:0] result,
    output logic             c_flag,
    output logic             z_flag,
    output logic             o_flag,
    output logic             s_flag
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Shared adder/subtractor operands.
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_sub;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;

    // Next-state values for the output registers.
    logic [WIDTH-1:0] w_result;
    logic             w_c;
    logic             w_o;

    // Registered outputs.
    logic [WIDTH-1:0] r_result;
    logic             r_c;
    logic             r_z;
    logic             r_o;
    logic             r_s;

    // Route every arithmetic opcode onto one x +/- y datapath.
    always_comb begin
        w_x   = op1;
        w_y   = op2;
        w_sub = 1'b0;
        case (opsel)
            3'b000: begin w_x = op1;    w_y = op2;   w_sub = 1'b0; end
            3'b001: begin w_x = op1;    w_y = op2;   w_sub = 1'b1; end
            3'b010: begin w_x = op1;    w_y = c_one; w_sub = 1'b0; end
            3'b011: begin w_x = op1;    w_y = c_one; w_sub = 1'b1; end
            3'b101: begin w_x = op2;    w_y = op1;   w_sub = 1'b1; end
            3'b110: begin w_x = c_zero; w_y = op1;   w_sub = 1'b1; end
            default: begin w_x = op1;   w_y = op2;   w_sub = 1'b0; end
        endcase
    end

    // The extra top bit is the carry on add and the borrow (x < y) on subtract.
    assign w_sum = w_sub ? ({1'b0, w_x} - {1'b0, w_y})
                         : ({1'b0, w_x} + {1'b0, w_y});

    // Signed overflow: operand signs agree (add) or differ (sub) and the
    // result sign differs from the first operand.
    assign w_ovf = w_sub ? ((w_x[WIDTH-1] != w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]))
                         : ((w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]));

    // Select result, carry and overflow for the current mode/opsel.
    always_comb begin
        w_result = c_zero;
        w_c      = 1'b0;
        w_o      = 1'b0;
        if (mode == 1'b0) begin
            case (opsel)
                3'b100: w_result = op1;
                3'b111: w_result = c_zero;
                default: begin
                    w_result = w_sum[WIDTH-1:0];
                    w_c      = w_sum[WIDTH];
                    w_o      = w_ovf;
                end
            endcase
        end else begin
            case (opsel)
                3'b000: w_result = op1 & op2;
                3'b001: w_result = op1 | op2;
                3'b010: w_result = op1 ^ op2;
                3'b011: w_result = ~op1;
                3'b100: w_result = ~(op1 | op2);
                3'b101: w_result = ~(op1 ^ op2);
                3'b110: begin
                    w_result = {op1[WIDTH-2:0], 1'b0};
                    w_c      = op1[WIDTH-1];
                end
                default: begin
                    w_result = {1'b0, op1[WIDTH-1:1]};
                    w_c      = op1[0];
                end
            endcase
        end
    end

    // Capture result and flags every edge; reset clears them asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= c_zero;
            r_c      <= 1'b0;
            r_z      <= 1'b0;
            r_o      <= 1'b0;
            r_s      <= 1'b0;
        end else begin
            r_result <= w_result;
            r_c      <= w_c;
            r_z      <= (w_result == c_zero);
            r_o      <= w_o;
            r_s      <= w_result[WIDTH-1];
        end
    end

    assign result = r_result;
    assign c_flag = r_c;
    assign z_flag = r_z;
    assign o_flag = r_o;
    assign s_flag = r_s;

endmodule
`default_nettype wire

// File: tb/tb_midterm_128bit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_midterm_128bit
// Description : Scoreboard-based self-checking bench for midterm_128bit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_midterm_128bit;

    localparam int W = 128;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         o;
        logic         s;
    } exp_t;

    localparam logic [W-1:0] c_ones = {W{1'b1}};
    localparam logic [W-1:0] c_smin = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] c_smax = {1'b0, {(W-1){1'b1}}};

    logic         clk;
    logic         rst;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [2:0]   opsel;
    logic         mode;
    logic [W-1:0] result;
    logic         c_flag;
    logic         z_flag;
    logic         o_flag;
    logic         s_flag;

    int   tests_run;
    int   tests_failed;
    exp_t sb[$];

    midterm_128bit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .op1    (op1),
        .op2    (op2),
        .opsel  (opsel),
        .mode   (mode),
        .result (result),
        .c_flag (c_flag),
        .z_flag (z_flag),
        .o_flag (o_flag),
        .s_flag (s_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic o);
        exp_t e;
        e.r = r;
        e.c = c;
        e.o = o;
        e.z = (r == '0);
        e.s = r[W-1];
        return e;
    endfunction

    function automatic logic signed [W+1:0] sx(input logic [W-1:0] v);
        return $signed({{2{v[W-1]}}, v});
    endfunction

    // Reference model: exact wide arithmetic, overflow when the true signed
    // value does not survive truncation to W bits.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] sel, input logic m);
        logic [W-1:0]          r;
        logic                  c;
        logic                  o;
        logic signed [W+1:0]   t;
        logic [W:0]            u;
        r = '0; c = 1'b0; o = 1'b0; t = '0;
        if (!m) begin
            case (sel)
                3'd0: begin u = {1'b0, a} + {1'b0, b}; r = u[W-1:0]; c = u[W]; t = sx(a) + sx(b); o = (t != sx(r)); end
                3'd1: begin r = a - b; c = (a < b); t = sx(a) - sx(b); o = (t != sx(r)); end
                3'd2: begin u = {1'b0, a} + 1; r = u[W-1:0]; c = u[W]; t = sx(a) + 1; o = (t != sx(r)); end
                3'd3: begin r = a - 1; c = (a == '0); t = sx(a) - 1; o = (t != sx(r)); end
                3'd4: r = a;
                3'd5: begin r = b - a; c = (b < a); t = sx(b) - sx(a); o = (t != sx(r)); end
                3'd6: begin r = '0 - a; c = (a != '0); t = -sx(a); o = (t != sx(r)); end
                default: r = '0;
            endcase
        end else begin
            case (sel)
                3'd0: r = a & b;
                3'd1: r = a | b;
                3'd2: r = a ^ b;
                3'd3: r = ~a;
                3'd4: r = ~(a | b);
                3'd5: r = ~(a ^ b);
                3'd6: begin r = a << 1; c = a[W-1]; end
                default: begin r = a >> 1; c = a[0]; end
            endcase
        end
        return mk(r, c, o);
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] sel, input logic m);
        op1 = a; op2 = b; opsel = sel; mode = m;
    endtask

    task automatic test_reset();
        exp_t obs;
        op1 = '0; op2 = '0; opsel = '0; mode = 1'b0; rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        obs = {result, c_flag, z_flag, o_flag, s_flag};
        tests_run++;
        if (obs !== '0) begin
            tests_failed++;
            $display("FAIL reset_async: got r=%h c%b z%b o%b s%b, want all zero", result, c_flag, z_flag, o_flag, s_flag);
        end
        drive(c_ones, 128'd1, 3'd0, 1'b0);
        @(posedge clk); #1;
        obs = {result, c_flag, z_flag, o_flag, s_flag};
        tests_run++;
        if (obs !== '0) begin
            tests_failed++;
            $display("FAIL reset_held: got r=%h c%b z%b o%b s%b, want all zero", result, c_flag, z_flag, o_flag, s_flag);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_arith();
        exp_t exp_v[7];
        exp_t obs;
        exp_t e;
        exp_v[0] = mk(128'd12, 1'b0, 1'b0);
        exp_v[1] = mk(c_ones - 128'd1, 1'b1, 1'b0);
        exp_v[2] = mk(128'd6, 1'b0, 1'b0);
        exp_v[3] = mk(128'd4, 1'b0, 1'b0);
        exp_v[4] = mk(128'd5, 1'b0, 1'b0);
        exp_v[5] = mk(128'd2, 1'b0, 1'b0);
        exp_v[6] = mk(c_ones - 128'd4, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(128'd5, 128'd7, 3'(i), 1'b0);
            sb.push_back(exp_v[i]);
            @(posedge clk); #1;
            obs = {result, c_flag, z_flag, o_flag, s_flag};
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL arith_%0d: scoreboard empty, got r=%h", i, result);
            end else begin
                e = sb.pop_front();
                if (obs !== e) begin
                    tests_failed++;
                    $display("FAIL arith_%0d: got r=%h c%b z%b o%b s%b, want r=%h c%b z%b o%b s%b",
                             i, obs.r, obs.c, obs.z, obs.o, obs.s, e.r, e.c, e.z, e.o, e.s);
                end
            end
        end
    endtask

    task automatic test_logic();
        exp_t exp_v[8];
        exp_t obs;
        exp_t e;
        exp_v[0] = mk(128'd5, 1'b0, 1'b0);
        exp_v[1] = mk(128'd7, 1'b0, 1'b0);
        exp_v[2] = mk(128'd2, 1'b0, 1'b0);
        exp_v[3] = mk(c_ones - 128'd5, 1'b0, 1'b0);
        exp_v[4] = mk(c_ones - 128'd7, 1'b0, 1'b0);
        exp_v[5] = mk(c_ones - 128'd2, 1'b0, 1'b0);
        exp_v[6] = mk(128'd10, 1'b0, 1'b0);
        exp_v[7] = mk(128'd2, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(128'd5, 128'd7, 3'(i), 1'b1);
            sb.push_back(exp_v[i]);
            @(posedge clk); #1;
            obs = {result, c_flag, z_flag, o_flag, s_flag};
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL logic_%0d: scoreboard empty, got r=%h", i, result);
            end else begin
                e = sb.pop_front();
                if (obs !== e) begin
                    tests_failed++;
                    $display("FAIL logic_%0d: got r=%h c%b z%b o%b s%b, want r=%h c%b z%b o%b s%b",
                             i, obs.r, obs.c, obs.z, obs.o, obs.s, e.r, e.c, e.z, e.o, e.s);
                end
            end
        end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] a_v[7];
        logic [W-1:0] b_v[7];
        logic [2:0]   s_v[7];
        logic         m_v[7];
        exp_t         exp_v[7];
        exp_t         obs;
        exp_t         e;
        a_v[0] = c_smax; b_v[0] = 128'd1; s_v[0] = 3'd0; m_v[0] = 1'b0; exp_v[0] = mk(c_smin, 1'b0, 1'b1);
        a_v[1] = c_ones; b_v[1] = 128'd1; s_v[1] = 3'd0; m_v[1] = 1'b0; exp_v[1] = mk('0, 1'b1, 1'b0);
        a_v[2] = c_ones; b_v[2] = 128'd1; s_v[2] = 3'd6; m_v[2] = 1'b1; exp_v[2] = mk(c_ones - 128'd1, 1'b1, 1'b0);
        a_v[3] = c_ones; b_v[3] = c_ones; s_v[3] = 3'd7; m_v[3] = 1'b0; exp_v[3] = mk('0, 1'b0, 1'b0);
        a_v[4] = c_smin; b_v[4] = '0;     s_v[4] = 3'd6; m_v[4] = 1'b0; exp_v[4] = mk(c_smin, 1'b1, 1'b1);
        a_v[5] = c_smin; b_v[5] = '0;     s_v[5] = 3'd3; m_v[5] = 1'b0; exp_v[5] = mk(c_smax, 1'b0, 1'b1);
        a_v[6] = '0;     b_v[6] = '0;     s_v[6] = 3'd3; m_v[6] = 1'b0; exp_v[6] = mk(c_ones, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(a_v[i], b_v[i], s_v[i], m_v[i]);
            sb.push_back(exp_v[i]);
            @(posedge clk); #1;
            obs = {result, c_flag, z_flag, o_flag, s_flag};
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL bound_%0d: scoreboard empty, got r=%h", i, result);
            end else begin
                e = sb.pop_front();
                if (obs !== e) begin
                    tests_failed++;
                    $display("FAIL bound_%0d: got r=%h c%b z%b o%b s%b, want r=%h c%b z%b o%b s%b",
                             i, obs.r, obs.c, obs.z, obs.o, obs.s, e.r, e.c, e.z, e.o, e.s);
                end
            end
        end
    endtask

    // Back-to-back random operations; inputs are also disturbed mid-cycle to
    // show the registered outputs hold until the next edge.
    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   sel;
        logic         m;
        exp_t         obs;
        exp_t         e;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a   = {$urandom, $urandom, $urandom, $urandom};
            b   = {$urandom, $urandom, $urandom, $urandom};
            if (i % 8 == 0) b = a;
            if (i % 8 == 1) a = c_smax;
            sel = 3'($urandom_range(0, 7));
            m   = 1'($urandom_range(0, 1));
            drive(a, b, sel, m);
            sb.push_back(model(a, b, sel, m));
            @(posedge clk); #1;
            obs = {result, c_flag, z_flag, o_flag, s_flag};
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL rand_%0d: scoreboard empty, got r=%h", i, result);
            end else begin
                e = sb.pop_front();
                if (obs !== e) begin
                    tests_failed++;
                    $display("FAIL rand_%0d m%b sel%0d: got r=%h c%b z%b o%b s%b, want r=%h c%b z%b o%b s%b",
                             i, m, sel, obs.r, obs.c, obs.z, obs.o, obs.s, e.r, e.c, e.z, e.o, e.s);
                end
                drive(~a, a ^ b, ~sel, ~m);
                #2;
                obs = {result, c_flag, z_flag, o_flag, s_flag};
                tests_run++;
                if (obs !== e) begin
                    tests_failed++;
                    $display("FAIL hold_%0d: got r=%h after mid-cycle input change, want r=%h", i, obs.r, e.r);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        exp_t obs;
        exp_t e;
        @(negedge clk);
        drive(128'd5, 128'd7, 3'd0, 1'b0);
        sb.push_back(mk(128'd12, 1'b0, 1'b0));
        @(posedge clk); #1;
        obs = {result, c_flag, z_flag, o_flag, s_flag};
        e = sb.pop_front();
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL midop_pre: got r=%h, want r=%h", obs.r, e.r);
        end
        #1 rst = 1'b1;
        sb.delete();
        #1;
        obs = {result, c_flag, z_flag, o_flag, s_flag};
        tests_run++;
        if (obs !== '0) begin
            tests_failed++;
            $display("FAIL midop_async_clear: got r=%h c%b z%b o%b s%b, want all zero", result, c_flag, z_flag, o_flag, s_flag);
        end
        @(posedge clk); #1;
        obs = {result, c_flag, z_flag, o_flag, s_flag};
        tests_run++;
        if (obs !== '0) begin
            tests_failed++;
            $display("FAIL midop_held: got r=%h, want 0", result);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(128'd5, 128'd7, 3'd1, 1'b0);
        sb.push_back(mk(c_ones - 128'd1, 1'b1, 1'b0));
        @(posedge clk); #1;
        obs = {result, c_flag, z_flag, o_flag, s_flag};
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL midop_release: scoreboard empty, got r=%h", result);
        end else begin
            e = sb.pop_front();
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL midop_release: got r=%h c%b z%b o%b s%b, want r=%h c%b z%b o%b s%b",
                         obs.r, obs.c, obs.z, obs.o, obs.s, e.r, e.c, e.z, e.o, e.s);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_arith();
        test_logic();
        test_boundaries();
        test_back_to_back();
        test_reset_midop();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/midterm_128bit.md
MIDTERM_128BIT -- requirements
Module: midterm_128bit

Interface
REQ-001 Parameter WIDTH, default 128, operand/result width; all requirements are stated at WIDTH=128.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 op1  input  WIDTH  operand A.
REQ-005 op2  input  WIDTH  operand B.
REQ-006 opsel  input  3  operation select.
REQ-007 mode  input  1  0 = arithmetic, 1 = logic.
REQ-008 result  output  WIDTH  registered result.
REQ-009 c_flag  output  1  carry/borrow/shift-out flag, registered.
REQ-010 z_flag  output  1  zero flag, registered.
REQ-011 o_flag  output  1  signed-overflow flag, registered.
REQ-012 s_flag  output  1  sign flag, registered.

Function
REQ-013 The block SHALL compute the selected operation combinationally from op1, op2, opsel and mode, and register result and all four flags on every rising clk edge; latency is 1 cycle, with no enable and no handshake.
REQ-014 Arithmetic mode (mode=0): 000 op1+op2; 001 op1-op2; 010 op1+1; 011 op1-1; 100 op1 (transfer); 101 op2-op1; 110 0-op1 (negate); 111 result 0.
REQ-015 Logic mode (mode=1): 000 op1&op2; 001 op1|op2; 010 op1^op2; 011 ~op1; 100 ~(op1|op2); 101 ~(op1^op2); 110 op1<<1 (zero fill); 111 op1>>1 logical (zero fill).
REQ-016 All arithmetic SHALL be modulo 2^WIDTH; the result wraps without saturation.
REQ-017 c_flag for add and increment: carry out of bit WIDTH-1.
REQ-018 c_flag for op1-op2, op1-1, op2-op1 and negate: borrow, 1 when the minuend is unsigned-less than the subtrahend.
REQ-019 c_flag for transfer and arithmetic 111: 0.
REQ-020 c_flag for logic shifts: the bit shifted out (op1[WIDTH-1] for 110, op1[0] for 111).
REQ-021 c_flag for all other logic ops: 0.
REQ-022 o_flag SHALL be two's-complement overflow for add, sub, inc, dec, reverse-sub and negate (negate of 0x8000...0 sets o_flag=1); otherwise 0.
REQ-023 z_flag = 1 when the result is all zeros; s_flag = result[WIDTH-1]; both apply in every mode and opsel.
REQ-024 Input changes within a cycle SHALL have no effect on outputs until the next rising edge.

Reset
REQ-025 While rst=1, result SHALL be 0 and c_flag, z_flag, o_flag and s_flag SHALL be 0, immediately and independent of clk.
REQ-026 Asserting rst mid-operation SHALL discard the in-flight result.
REQ-027 After rst deasserts, the first rising edge SHALL capture the currently selected operation.

Verification
REQ-028 op1=5, op2=7, mode=0, opsel 000..110 in consecutive cycles -> results 12, 0xFFFF...FFFE (c=1, s=1), 6, 4, 5, 2, 0xFFFF...FFFB (c=1, s=1), each one cycle after its stimulus; o=0 and z=0 throughout.
REQ-029 op1=5, op2=7, mode=1, opsel 000..100 -> results 5, 7, 2, 0xFFFF...FFFA (s=1), 0xFFFF...FFF8 (s=1); c=0 and o=0 throughout.
REQ-030 op1=0x7FFF...FFFF, op2=1, add -> result 0x8000...0000, o=1, s=1, c=0, z=0.
REQ-031 op1=all ones, op2=1, add -> result 0, c=1, z=1, o=0, s=0; the same op1 with logic 110 -> result 0xFFFF...FFFE, c=1.
REQ-032 Arithmetic 111 -> result 0 with z=1, c=0, o=0, s=0.
REQ-033 Pulse rst between clock edges during any nonzero result -> outputs go to 0 immediately, stay 0 while rst=1, and the correct result appears one edge after release.
